mem_op_controller: RTL and testbench
====================================

# mem_op_controller

Memory-operation sequencer sitting between the microprogrammed control unit and the data RAM. It accepts a memory request from the control word (MOV, R/W, size, signedness) plus the MAR/MDR contents, and runs the RAM access with a fixed number of wait states. It handles byte-lane steering, alignment checking and read sign/zero extension. It returns the one-cycle MOC pulse that the control unit's next-state logic waits on.

## Interface
Parameters:
- WAIT_STATES, 2: RAM wait cycles per access; legal range 0..15.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- MOV  in  1  memory operation request from the control word; held high by the microprogram until MOC is seen.
- RW  in  1  1 = read, 0 = write.
- SIZE  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- SIGNED  in  1  sign-extend byte/halfword reads when 1; zero-extend when 0.
- ADDR  in  32  byte address from MAR.
- WDATA  in  32  store data from MDR; the value is right-aligned.
- RDATA  out  32  load result to MDR, right-aligned and extended.
- MOC  out  1  memory operation complete; one-cycle pulse.
- ABORT  out  1  misaligned or reserved-size request; asserted only in the same cycle as its MOC.
- mem_en  out  1  RAM strobe.
- mem_we  out  1  RAM write enable.
- mem_be  out  4  RAM byte enables; bit i = byte lane i (little-endian).
- mem_addr  out  30  word address, ADDR[31:2].
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  RAM read word; valid while mem_en is high.

## Operation
- FSM states: IDLE, ACCESS, DONE, RELEASE.
- **IDLE**
  - If MOV = 1, capture ADDR, WDATA, RW, SIZE and SIGNED into registers.
  - Aligned request: go to ACCESS and load the counter with WAIT_STATES.
  - Misaligned request: go straight to DONE with the abort flag set. Misaligned means word with ADDR[1:0] ≠ 0, halfword with ADDR[0] ≠ 0, or SIZE = 11.
- **ACCESS**
  - mem_en = 1; mem_we = !RW; outputs are driven from the captured registers only.
  - Each edge with counter ≠ 0 decrements the counter.
  - At the edge with counter = 0: for a read, latch the extracted mem_rdata into RDATA; go to DONE.
- **DONE**
  - MOC = 1 for exactly one cycle; ABORT = abort flag.
  - Next state is IDLE if MOV = 0, otherwise RELEASE.
- **RELEASE**
  - MOC = 0; stay until MOV = 0, then go to IDLE.
  - A new request is never accepted while MOV stays high after completion.
- **Lane steering**
  - mem_be: byte = 0001 << ADDR[1:0]; half = 0011 << ADDR[1:0]; word = 1111.
  - mem_wdata: byte = {4{WDATA[7:0]}}; half = {2{WDATA[15:0]}}; word = WDATA.
- **Read extraction**
  - Byte: take byte lane ADDR[1:0]. Halfword: take halfword ADDR[1].
  - Extend to 32 bits according to SIGNED.
- Writes leave RDATA unchanged. Aborted requests never assert mem_en, and RDATA is unchanged.

## Timing
- Reset values: state IDLE, MOC 0, ABORT 0, RDATA 0, mem_en 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0.
- RESET overrides everything. Asserted mid-ACCESS, it deasserts mem_en on the following cycle with no MOC.
- All outputs are registered or decoded from registered state; no combinational path from MOV to MOC.
- Aligned access latency: MOV sampled at edge k; mem_en high for cycles k+1 .. k+1+WAIT_STATES; MOC high in the cycle after edge k+WAIT_STATES+1.
  - With WAIT_STATES = 2, MOC is high 3 cycles after the request edge.
  - With WAIT_STATES = 0, mem_en is high for one cycle and MOC follows immediately after.
- Abort latency: MOC and ABORT are high in the cycle after edge k.
- Input changes during ACCESS are ignored, because captured values are used.
- MOV dropping during ACCESS does not cancel the access; the MOC pulse still occurs.

## Structure
- Shared package arm_mem_pkg holds:
  - SIZE encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state enum.
  - RW polarity constants.
- Sub-module mem_lane_align: purely combinational. Computes the be/wdata replication, the read extraction and extension, and the misalign flag. It is instantiated once, fed from the captured registers.
- The counter width is fixed at 4 bits.

## Test plan
- Word read, ADDR = 0x00000104, RAM returns 0xDEADBEEF, WAIT_STATES = 2 -> mem_be = 1111, mem_addr = 0x41; MOC pulses 3 cycles after the request edge; RDATA = 0xDEADBEEF; ABORT = 0.
- Signed byte read, ADDR = 0x00000103, mem_rdata = 0x80FF1234 -> mem_be = 1000; RDATA = 0xFFFFFF80. Same access with SIGNED = 0 -> RDATA = 0x00000080.
- Halfword write, ADDR = 0x00000202, WDATA = 0x0000ABCD -> mem_we = 1, mem_be = 1100, mem_wdata = 0xABCDABCD; RDATA unchanged.
- Misaligned word read, ADDR = 0x00000102 -> mem_en never asserted; MOC = ABORT = 1 in the cycle after the request edge.
- Handshake: MOV held 5 cycles past MOC -> exactly one MOC pulse and one mem_en burst. A second request after MOV drops completes normally.
- RESET asserted in the second ACCESS cycle -> next cycle mem_en = 0, MOC = 0, RDATA = 0, state IDLE; no MOC pulse afterwards.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared encodings for the memory-operation sequencer: request sizes, read/write
// polarity, FSM states and the alignment rule used by both the FSM and the lane aligner.
package arm_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACCESS  = 2'b01,
    ST_DONE    = 2'b10,
    ST_RELEASE = 2'b11
  } state_e;

  // Reserved size is always treated as a misaligned (aborting) request.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_op_controller_if.sv
// Control-unit and RAM side signals of the memory-operation sequencer.
// The controller uses the slave modport; the environment drives through master.
interface mem_op_controller_if;
  logic        MOV;
  logic        RW;
  logic [1:0]  SIZE;
  logic        SIGNED;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic        MOC;
  logic        ABORT;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  MOV, RW, SIZE, SIGNED, ADDR, WDATA, mem_rdata,
    output RDATA, MOC, ABORT, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output MOV, RW, SIZE, SIGNED, ADDR, WDATA, mem_rdata,
    input  RDATA, MOC, ABORT, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: byte enables and store replication for writes,
// lane extraction plus sign/zero extension for reads, and the misalign flag.
module mem_lane_align
  import arm_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte lane of the RAM word.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      2'd3:    byte_s = rdata_i[31:24];
      default: byte_s = 8'h00;
    endcase
  end

  assign half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Per-size enables, replication and extension.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    rdata_o = 32'h0000_0000;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & byte_s[7]}}, byte_s};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{signed_i & half_s[15]}}, half_s};
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
        rdata_o = 32'h0000_0000;
      end
    endcase
  end

  assign misalign_o = is_misaligned(size_i, addr_lo_i);

endmodule

// File: rtl/mem_op_controller.sv
// Memory-operation sequencer: captures a MOV request, runs one RAM access with a fixed
// number of wait states (or aborts a misaligned request) and returns a one-cycle MOC.
module mem_op_controller
  import arm_mem_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  mem_op_controller_if.slave bus
);

  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rw_q, rw_d;
  logic             signed_q, signed_d;
  logic [1:0]       size_q, size_d;

  logic [3:0]       be_s;
  logic [31:0]      lane_wdata_s;
  logic [31:0]      rd_ext_s;
  logic             misalign_s;
  logic             access_s;
  logic             done_s;

  mem_lane_align u_align (
    .size_i     (size_q),
    .signed_i   (signed_q),
    .addr_lo_i  (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (bus.mem_rdata),
    .be_o       (be_s),
    .wdata_o    (lane_wdata_s),
    .rdata_o    (rd_ext_s),
    .misalign_o (misalign_s)
  );

  // State, wait counter, captured request and load result registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      rw_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rw_q     <= rw_d;
      signed_q <= signed_d;
      size_q   <= size_d;
    end
  end

  // Next-state logic; the abort decision uses the live request, everything later the capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rw_d     = rw_q;
    signed_d = signed_q;
    size_d   = size_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.MOV) begin
          addr_d   = bus.ADDR;
          wdata_d  = bus.WDATA;
          rw_d     = bus.RW;
          size_d   = bus.SIZE;
          signed_d = bus.SIGNED;
          if (is_misaligned(bus.SIZE, bus.ADDR[1:0])) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = WS_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = ST_DONE;
          if (rw_q == RW_READ) begin
            rdata_d = rd_ext_s;
          end else begin
            rdata_d = rdata_q;
          end
        end
      end
      ST_DONE: begin
        if (bus.MOV) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (bus.MOV) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign access_s = (state_q == ST_ACCESS);
  assign done_s   = (state_q == ST_DONE);

  // RAM strobes are forced low outside ACCESS so aborted requests never touch the RAM.
  assign bus.mem_en    = access_s;
  assign bus.mem_we    = access_s & (rw_q == RW_WRITE);
  assign bus.mem_be    = access_s ? be_s : 4'b0000;
  assign bus.mem_addr  = access_s ? addr_q[31:2] : 30'h0000_0000;
  assign bus.mem_wdata = access_s ? lane_wdata_s : 32'h0000_0000;
  assign bus.MOC       = done_s;
  assign bus.ABORT     = done_s & misalign_s;
  assign bus.RDATA     = rdata_q;

endmodule

// File: tb/tb_mem_op_controller.sv
// Self-checking bench for mem_op_controller: directed plan items plus random requests
// checked cycle by cycle against an arithmetic model of the request rules.
module tb_mem_op_controller;

  localparam int WS = 2;

  logic CLK;
  logic RESET;
  int   total;
  int   passes;
  logic [31:0] model_rdata;

  mem_op_controller_if bus ();

  mem_op_controller #(.WAIT_STATES(WS)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One request: MOV raised at a negedge, sampled on the next rising edge (edge k);
  // negedge n lies in the cycle after edge k+n-1. MOV drops at negedge drop_n.
  task automatic run_req(input logic rw, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] word, input int drop_n);
    logic mis, en_e;
    int moc_n, last_n, mocs, sh;
    logic [31:0] be_e, wd_e, rd_e;
    mis = (sz == 2'b11) || (sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
    moc_n = mis ? 1 : WS + 2;
    last_n = ((drop_n > moc_n) ? drop_n : moc_n) + 2;
    be_e = 32'd0; wd_e = 32'd0; rd_e = 32'd0;
    if (sz == 2'b00) begin
      be_e = 32'd1 << a[1:0];
      wd_e = {24'd0, wd[7:0]} * 32'h0101_0101;
      sh   = 8 * int'(a[1:0]);
      rd_e = (word >> sh) & 32'h0000_00FF;
      if (sg && rd_e[7]) rd_e = rd_e | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      be_e = 32'd3 << a[1:0];
      wd_e = {16'd0, wd[15:0]} * 32'h0001_0001;
      sh   = 16 * int'(a[1]);
      rd_e = (word >> sh) & 32'h0000_FFFF;
      if (sg && rd_e[15]) rd_e = rd_e | 32'hFFFF_0000;
    end else begin
      be_e = 32'hF;
      wd_e = wd;
      rd_e = word;
    end
    @(negedge CLK);
    bus.MOV = 1'b1; bus.RW = rw; bus.SIZE = sz; bus.SIGNED = sg;
    bus.ADDR = a; bus.WDATA = wd; bus.mem_rdata = word;
    mocs = 0;
    for (int n = 1; n <= last_n; n++) begin
      @(negedge CLK);
      en_e = !mis && (n <= WS + 1);
      chk("mem_en", 32'(bus.mem_en), 32'(en_e));
      chk("moc", 32'(bus.MOC), 32'(n == moc_n));
      chk("abort", 32'(bus.ABORT), 32'(n == moc_n && mis));
      if (bus.MOC) mocs++;
      if (en_e) begin
        chk("mem_we", 32'(bus.mem_we), 32'(!rw));
        chk("mem_be", 32'(bus.mem_be), be_e);
        chk("mem_addr", 32'(bus.mem_addr), a >> 2);
        chk("mem_wdata", bus.mem_wdata, wd_e);
      end
      if (n == moc_n) begin
        if (!mis && rw) model_rdata = rd_e;
        chk("rdata", bus.RDATA, model_rdata);
      end
      if (n == 1) begin
        bus.ADDR = $urandom; bus.WDATA = $urandom; bus.RW = 1'($urandom_range(0, 1));
        bus.SIZE = 2'($urandom_range(0, 3)); bus.SIGNED = 1'($urandom_range(0, 1));
      end
      if (n == drop_n) bus.MOV = 1'b0;
    end
    chk("moc_count", 32'(mocs), 32'd1);
    chk("rdata_end", bus.RDATA, model_rdata);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    total = 0; passes = 0; model_rdata = 32'd0;
    RESET = 1'b1;
    bus.MOV = 1'b0; bus.RW = 1'b0; bus.SIZE = 2'b00; bus.SIGNED = 1'b0;
    bus.ADDR = 32'd0; bus.WDATA = 32'd0; bus.mem_rdata = 32'd0;
    repeat (2) @(negedge CLK);
    chk("rst_moc", 32'(bus.MOC), 32'd0);
    chk("rst_abort", 32'(bus.ABORT), 32'd0);
    chk("rst_rdata", bus.RDATA, 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    RESET = 1'b0;

    // Directed plan items.
    run_req(1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, WS + 2);
    run_req(1'b1, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_1234, WS + 2);
    run_req(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_1234, WS + 2);
    run_req(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h1111_2222, WS + 2);
    run_req(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 32'h5555_AAAA, 1);
    run_req(1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 3);
    run_req(1'b1, 2'b01, 1'b1, 32'h0000_0306, 32'h0, 32'h9234_0001, WS + 7);
    run_req(1'b1, 2'b01, 1'b0, 32'h0000_0300, 32'h0, 32'h0000_F00D, WS + 2);
    run_req(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h0123_4567, 2);
    run_req(1'b1, 2'b01, 1'b0, 32'h0000_0401, 32'h0, 32'h0123_4567, 2);

    // Random requests, biased toward aligned addresses.
    for (int i = 0; i < 40; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = (rs == 2'b00) ? ra[1:0] : {ra[1] & ~rs[1], 1'b0};
      run_req(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom, $urandom,
              $urandom_range(1, 8));
    end

    // Reset in the second ACCESS cycle of a read.
    @(negedge CLK);
    bus.MOV = 1'b1; bus.RW = 1'b1; bus.SIZE = 2'b10; bus.SIGNED = 1'b0;
    bus.ADDR = 32'h0000_0200; bus.mem_rdata = 32'hCAFE_F00D;
    @(negedge CLK);
    chk("rst_mid_en1", 32'(bus.mem_en), 32'd1);
    @(negedge CLK);
    chk("rst_mid_en2", 32'(bus.mem_en), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; bus.MOV = 1'b0; model_rdata = 32'd0;
    chk("rst_mid_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mid_moc", 32'(bus.MOC), 32'd0);
    chk("rst_mid_rdata", bus.RDATA, 32'd0);
    for (int n = 0; n < 5; n++) begin
      @(negedge CLK);
      chk("rst_after_moc", 32'(bus.MOC), 32'd0);
      chk("rst_after_en", 32'(bus.mem_en), 32'd0);
    end
    run_req(1'b1, 2'b00, 1'b1, 32'h0000_0101, 32'h0, 32'h0000_7F00, WS + 2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
